// File: rtl/pes_1_n_demux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pes_1_n_demux_seq
//  Description : Parametrised 1:N registered demultiplexer with valid/ready
//                handshake. Routes one input stream to one of NCH = 2**SELW
//                channels, by explicit select (mode=0) or by an internal
//                auto-advancing pointer (mode=1). Each channel owns a
//                one-entry output register, so a stalled consumer never
//                blocks the other channels.
//                Optional macro PES_DEMUX_CNT_EN adds per-channel saturating
//                accepted-transfer counters on the xfer_cnt port.
//  Revision    : 1.0 - initial release
// ============================================================================
module pes_1_n_demux_seq #(
    parameter int DW   = 8,
    parameter int SELW = 2,
    parameter int CW   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_data,
    input  logic [SELW-1:0]               sel,
    input  logic                          mode,
    output logic [(2**SELW)-1:0]          out_valid,
    input  logic [(2**SELW)-1:0]          out_ready,
    output logic [(2**SELW)*DW-1:0]       out_data,
    output logic [SELW-1:0]               cur_ptr
`ifdef PES_DEMUX_CNT_EN
    ,
    output logic [(2**SELW)*CW-1:0]       xfer_cnt
`endif
);

    localparam int NCH = 2**SELW;

    logic [SELW-1:0] r_ptr;
    logic [NCH-1:0]  r_valid;
    logic [DW-1:0]   r_data [NCH];

    logic [SELW-1:0] w_tgt;
    logic            w_in_ready;
    logic            w_accept;

    // Target channel is resolved every cycle so sel/mode may change while stalled
    assign w_tgt      = mode ? r_ptr : sel;
    // Target can take a word when empty or when its current word leaves this cycle
    assign w_in_ready = !reset && (!r_valid[w_tgt] || out_ready[w_tgt]);
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign cur_ptr   = r_ptr;

    // Sequencer pointer: advances only on accepts made in auto mode, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept && mode) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            logic w_load;

            assign w_load = w_accept && (w_tgt == SELW'(k));
            assign out_data[k*DW +: DW] = r_data[k];

            // Per-channel register: a load wins over a drain, so drain+load keeps valid high
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_load) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end

`ifdef PES_DEMUX_CNT_EN
            logic [CW-1:0] r_cnt;

            assign xfer_cnt[k*CW +: CW] = r_cnt;

            // Accepted-transfer counter, sticks at all-ones until reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (w_load && (r_cnt != {CW{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pes_1_n_demux_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pes_1_n_demux_seq
//  Description : Self-checking bench for pes_1_n_demux_seq (4 channels, 8-bit
//                data, 2-bit counters when PES_DEMUX_CNT_EN is defined).
//                Directed scenarios followed by randomized traffic, all
//                compared against a behavioural channel/queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pes_1_n_demux_seq;

    localparam int DW   = 8;
    localparam int SELW = 2;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SELW-1:0]   sel;
    logic              mode;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_data;
    logic [SELW-1:0]   cur_ptr;
`ifdef PES_DEMUX_CNT_EN
    logic [NCH*CW-1:0] xfer_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: each channel either holds a word or not
    bit      m_full [NCH];
    int      m_word [NCH];
    int      m_ptr;
    int      m_cnt  [NCH];

    pes_1_n_demux_seq #(.DW(DW), .SELW(SELW), .CW(CW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_ptr   (cur_ptr)
`ifdef PES_DEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_full[k] = 0;
            m_word[k] = 0;
            m_cnt[k]  = 0;
        end
        m_ptr = 0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    // Returns at posedge+1 so callers can inspect the freshly updated state.
    task automatic cycle(input logic rst, input logic iv, input logic [7:0] d,
                         input logic [1:0] s, input logic m, input logic [3:0] ordy);
        int  t;
        bit  rdy;
        logic [3:0] vexp;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_data   = d;
        sel       = s;
        mode      = m;
        out_ready = ordy;
        #1;
        t   = m ? m_ptr : int'(s);
        rdy = !rst && (!m_full[t] || ordy[t]);
        for (int k = 0; k < NCH; k++) vexp[k] = m_full[k];
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, vexp);
        check("cur_ptr", cur_ptr, m_ptr);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("out_data%0d", k), out_data[k*DW +: DW], m_word[k]);
`ifdef PES_DEMUX_CNT_EN
            check($sformatf("xfer_cnt%0d", k), xfer_cnt[k*CW +: CW], m_cnt[k]);
`endif
        end
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < NCH; k++)
                if (m_full[k] && ordy[k]) m_full[k] = 0;
            if (iv && rdy) begin
                m_full[t] = 1;
                m_word[t] = d;
                if (m_cnt[t] < CMAX) m_cnt[t]++;
                if (m) m_ptr = (m_ptr + 1) % NCH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; mode = 1'b0; out_ready = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset held with in_valid asserted
        cycle(1, 1, 8'hFF, 0, 0, 4'h0);
        cycle(1, 1, 8'hFF, 0, 0, 4'h0);
        check("rst_valid", out_valid, 4'b0000);
        check("rst_ptr", cur_ptr, 0);

        // Explicit select into a stalled channel 2
        cycle(0, 1, 8'hA5, 2, 0, 4'h0);
        check("t2_valid", out_valid, 4'b0100);
        check("t2_data", out_data[23:16], 8'hA5);
        in_valid = 1'b0; sel = 2; #1;
        check("t2_rdy_sel2", in_ready, 0);
        sel = 1; #1;
        check("t2_rdy_sel1", in_ready, 1);

        // Auto sequence with wrap
        cycle(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 8'(8'h10 + i), 0, 1, 4'hF);
            check("t3_ptr", cur_ptr, (i + 1) % NCH);
        end
        check("t3_ch0", out_data[7:0], 8'h14);

        // Drain and load of channel 1 in the same cycle
        cycle(0, 1, 8'h11, 1, 0, 4'h0);
        cycle(0, 1, 8'h22, 1, 0, 4'b0010);
        check("t4_valid1", out_valid[1], 1);
        check("t4_data1", out_data[15:8], 8'h22);

        // Stall at pointer 3 without skipping
        cycle(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h30 + i), 0, 1, 4'hF);
        cycle(0, 1, 8'h3F, 3, 0, 4'h0);
        check("t5_ptr3", cur_ptr, 3);
        cycle(0, 1, 8'h40, 0, 1, 4'h0);
        cycle(0, 1, 8'h40, 0, 1, 4'h0);
        check("t5_ptr_hold", cur_ptr, 3);
        cycle(0, 1, 8'h41, 0, 1, 4'b1000);
        check("t5_ptr_wrap", cur_ptr, 0);
        check("t5_ch3", out_data[31:24], 8'h41);

        // Five accepts to channel 0, then reset mid-operation
        cycle(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h50 + i), 0, 0, 4'b0001);
`ifdef PES_DEMUX_CNT_EN
        check("t6_sat", xfer_cnt[1:0], 2'd3);
`endif
        cycle(1, 1, 8'h99, 0, 0, 4'h0);
        check("t6_valid", out_valid, 4'b0000);
`ifdef PES_DEMUX_CNT_EN
        check("t6_cnt", xfer_cnt, 8'h00);
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
                  4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
